alu_dispatch: RTL and testbench

- Upstream issue/sequencing stage for the multi-function ALU (ops 000 AND, 001 OR, 010 XOR, 011 NOR, 100 LT, 101 ADD, 110 SUB, 111 MOD).
- Accepts operation requests over a valid/ready handshake and holds the ALU operands stable.
- Runs the multi-cycle MOD start/done handshake, with divide-by-zero and timeout protection.
- Returns the tagged result over a valid/ready response handshake to writeback.

---
 rtl/alu_dispatch.sv | 155 +++++++++++++++
 tb/tb_alu_dispatch.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch.sv
// alu_dispatch
// Issue/sequencing stage in front of the multi-function ALU.
// It accepts one operation at a time, holds the operands stable at the ALU
// inputs, and runs the multi-cycle MOD start/done handshake. A MOD by zero
// and a MOD that never completes both return an error response. The tagged
// result is then offered to writeback.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds valid and its payload until that edge, and the
// consumer may not make ready depend on valid. This design raises req_ready
// only in IDLE and rsp_valid only in RESP. While rsp_valid is 1 the rsp_*
// payload does not change.
//
// Ports:
//   clk, reset                   clock; synchronous active-high reset
//   req_valid/req_ready          request handshake
//   req_a, req_b, req_op, req_dst   operands, opcode, destination tag
//   alu_a, alu_b, alu_op         registered operands/opcode to the ALU
//   alu_start                    MOD start, held until done or timeout
//   alu_res, alu_carry, alu_done ALU result, carry, MOD completion
//   rsp_valid/rsp_ready          response handshake
//   rsp_res, rsp_carry, rsp_dst, rsp_err   captured response payload
module alu_dispatch #(
  parameter int WIDTH       = 32,
  parameter int TAG_W       = 5,
  parameter int MOD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  input  logic [TAG_W-1:0] req_dst,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_carry,
  input  logic             alu_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_res,
  output logic             rsp_carry,
  output logic [TAG_W-1:0] rsp_dst,
  output logic             rsp_err
);

  localparam logic [2:0] OP_MOD = 3'b111;
  localparam int CNT_W = $clog2(MOD_TIMEOUT + 1);
  // The counter reads k-1 on the k-th edge spent in MOD_WAIT. The timeout
  // therefore fires on edge MOD_TIMEOUT, where alu_done still takes priority.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MOD_WAIT = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic             mod_timeout;

  assign mod_timeout = (cnt == CNT_LAST);
  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_op != OP_MOD)      state_d = EXEC;
          else if (req_b != '0)      state_d = MOD_WAIT;
          else                       state_d = RESP;
        end
      end
      EXEC:     state_d = RESP;
      MOD_WAIT: if (alu_done || mod_timeout) state_d = RESP;
      RESP:     if (rsp_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Operand, start, counter and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_start <= 1'b0;
      rsp_res   <= '0;
      rsp_carry <= 1'b0;
      rsp_dst   <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            alu_a   <= req_a;
            alu_b   <= req_b;
            alu_op  <= req_op;
            rsp_dst <= req_dst;
            cnt     <= '0;
            if (req_op == OP_MOD) begin
              if (req_b != '0) begin
                alu_start <= 1'b1;
              end else begin
                // Divide by zero: the ALU is never started and A is returned.
                rsp_res   <= req_a;
                rsp_carry <= 1'b0;
                rsp_err   <= 1'b1;
              end
            end
          end
        end
        EXEC: begin
          rsp_res   <= alu_res;
          rsp_carry <= alu_carry;
          rsp_err   <= 1'b0;
        end
        MOD_WAIT: begin
          if (alu_done) begin
            rsp_res   <= alu_res;
            rsp_carry <= alu_carry;
            rsp_err   <= 1'b0;
            alu_start <= 1'b0;
          end else if (mod_timeout) begin
            rsp_res   <= '0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b1;
            alu_start <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch
// Self-checking bench for alu_dispatch, built with MOD_TIMEOUT = 8.
// A bench-side ALU model drives alu_res/alu_carry and raises alu_done a
// chosen number of cycles after alu_start rises. While alu_start is low it
// also drives random, meaningless alu_done pulses. A transaction-level
// reference predicts each response and the cycle on which it appears. A
// compare process checks the DUT against that prediction on every cycle.
module tb_alu_dispatch;

  localparam int W  = 32;
  localparam int TW = 5;
  localparam int T  = 8;
  localparam int EW = 1 + 1 + TW + W;  // {err, carry, dst, res}

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_a, req_b;
  logic [2:0]    req_op;
  logic [TW-1:0] req_dst;
  logic [W-1:0]  alu_a, alu_b;
  logic [2:0]    alu_op;
  logic          alu_start;
  logic [W-1:0]  alu_res;
  logic          alu_carry;
  logic          alu_done;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_res;
  logic          rsp_carry;
  logic [TW-1:0] rsp_dst;
  logic          rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  alu_dispatch #(.WIDTH(W), .TAG_W(TW), .MOD_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_dst(req_dst),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_res(alu_res), .alu_carry(alu_carry), .alu_done(alu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_carry(rsp_carry), .rsp_dst(rsp_dst), .rsp_err(rsp_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- ALU model ----------------
  // Result in [W-1:0]. Carry in [W]: carry-out for ADD, borrow for SUB.
  function automatic logic [W:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0: alu_fn = {1'b0, a & b};
      3'd1: alu_fn = {1'b0, a | b};
      3'd2: alu_fn = {1'b0, a ^ b};
      3'd3: alu_fn = {1'b0, ~(a | b)};
      3'd4: alu_fn = {1'b0, W'(a < b)};
      3'd5: alu_fn = {1'b0, a} + {1'b0, b};
      3'd6: alu_fn = {a < b, a - b};
      default: alu_fn = {1'b0, (b == '0) ? a : a % b};
    endcase
  endfunction

  assign {alu_carry, alu_res} = alu_fn(alu_a, alu_b, alu_op);

  int done_delay = 1;  // alu_done is sampled on the done_delay-th edge with alu_start high
  int start_cnt  = 0;
  always @(posedge clk) begin
    #1;
    if (alu_start === 1'b1) start_cnt++;
    else                    start_cnt = 0;
    if (alu_start === 1'b1) alu_done = (start_cnt == done_delay);
    else                    alu_done = ($urandom_range(0, 3) == 0);
  end

  // ---------------- reference model / scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  exp_a, exp_b;
  logic [2:0]    exp_op;
  logic          exp_mod_run;
  int            edge_n = 0;
  int            due    = 0;
  bit            checking = 0;

  always @(posedge clk) begin
    logic [W:0] r;
    int lat;
    if (reset === 1'b1) begin
      exp_q.delete();
    end else if (exp_q.size() != 0) begin
      if (edge_n >= due && rsp_ready) void'(exp_q.pop_front());
    end else if (req_valid) begin
      exp_a = req_a; exp_b = req_b; exp_op = req_op;
      exp_mod_run = 1'b0;
      if (req_op != 3'b111) begin
        r = alu_fn(req_a, req_b, req_op);
        exp_q.push_back({1'b0, r[W], req_dst, r[W-1:0]});
        lat = 2;
      end else if (req_b == '0) begin
        exp_q.push_back({1'b1, 1'b0, req_dst, req_a});
        lat = 1;
      end else if (done_delay <= T) begin
        r = alu_fn(req_a, req_b, req_op);
        exp_q.push_back({1'b0, r[W], req_dst, r[W-1:0]});
        exp_mod_run = 1'b1;
        lat = done_delay + 1;
      end else begin
        exp_q.push_back({1'b1, 1'b0, req_dst, {W{1'b0}}});
        exp_mod_run = 1'b1;
        lat = T + 1;
      end
      due = edge_n + lat;
    end
    edge_n++;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit in_rsp;
    if (checking) begin
      if (exp_q.size() == 0) begin
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
        chk("alu_start_idle", 64'(alu_start), 64'd0);
      end else begin
        in_rsp = (edge_n >= due);
        chk("req_ready_busy", 64'(req_ready), 64'd0);
        chk("rsp_valid", 64'(rsp_valid), 64'(in_rsp));
        chk("alu_start", 64'(alu_start), 64'(exp_mod_run && !in_rsp));
        chk("alu_a", 64'(alu_a), 64'(exp_a));
        chk("alu_b", 64'(alu_b), 64'(exp_b));
        chk("alu_op", 64'(alu_op), 64'(exp_op));
        if (in_rsp) begin
          chk("rsp_res",   64'(rsp_res),   64'(exp_q[0][W-1:0]));
          chk("rsp_dst",   64'(rsp_dst),   64'(exp_q[0][W+TW-1:W]));
          chk("rsp_carry", 64'(rsp_carry), 64'(exp_q[0][W+TW]));
          chk("rsp_err",   64'(rsp_err),   64'(exp_q[0][W+TW+1]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic scramble();
    req_a  = $urandom;
    req_b  = $urandom;
    req_op = 3'($urandom_range(0, 7));
    req_dst = TW'($urandom_range(0, 31));
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                      input logic [TW-1:0] dst, input int dly);
    bit rdy;
    bit ok = 0;
    @(negedge clk);
    done_delay = dly;
    req_a = a; req_b = b; req_op = op; req_dst = dst;
    req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      rdy = req_ready;
      @(posedge clk);
      if (rdy) begin ok = 1; break; end
      @(negedge clk);
    end
    #1;
    req_valid = 1'b0;
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic get_rsp(input int hold, output logic [W-1:0] r, output logic c,
                         output logic [TW-1:0] d, output logic e);
    bit got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1; break; end
      scramble();
    end
    if (!got) chk("rsp_timeout", 64'd0, 64'd1);
    r = rsp_res; c = rsp_carry; d = rsp_dst; e = rsp_err;
    repeat (hold) begin
      scramble();
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks", n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0]  r;
    logic          c, e;
    logic [TW-1:0] d;
    logic [2:0]    op;
    logic [W-1:0]  b;

    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0; req_dst = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_alu_start", 64'(alu_start), 64'd0);
    chk("rst_alu_a",     64'(alu_a),     64'd0);
    chk("rst_alu_b",     64'(alu_b),     64'd0);
    chk("rst_alu_op",    64'(alu_op),    64'd0);
    chk("rst_rsp_res",   64'(rsp_res),   64'd0);
    chk("rst_rsp_carry", 64'(rsp_carry), 64'd0);
    chk("rst_rsp_dst",   64'(rsp_dst),   64'd0);
    chk("rst_rsp_err",   64'(rsp_err),   64'd0);
    reset = 1'b0;
    checking = 1;

    // AND
    send(32'hFFFF_FFFF, 32'h1D, 3'b000, 5'd3, 1);
    get_rsp(0, r, c, d, e);
    chk("and_res", 64'(r), 64'h1D);
    chk("and_dst", 64'(d), 64'd3);
    chk("and_err", 64'(e), 64'd0);

    // ADD with three cycles of backpressure
    send(32'hFFFF_FFFF, 32'd1, 3'b101, 5'd7, 1);
    get_rsp(3, r, c, d, e);
    chk("add_res",   64'(r), 64'd0);
    chk("add_carry", 64'(c), 64'd1);
    chk("add_err",   64'(e), 64'd0);

    // Modulo with done four cycles after start
    send(32'd15, 32'd2, 3'b111, 5'd9, 4);
    get_rsp(0, r, c, d, e);
    chk("mod_res", 64'(r), 64'd1);
    chk("mod_err", 64'(e), 64'd0);

    // Modulo by zero
    send(32'd15, 32'd0, 3'b111, 5'd10, 4);
    get_rsp(1, r, c, d, e);
    chk("mod0_res", 64'(r), 64'd15);
    chk("mod0_err", 64'(e), 64'd1);

    // Modulo timeout (done never raised)
    send(32'd15, 32'd2, 3'b111, 5'd11, 1000);
    get_rsp(0, r, c, d, e);
    chk("modto_res", 64'(r), 64'd0);
    chk("modto_err", 64'(e), 64'd1);

    // done on the same edge as the timeout: done wins
    send(32'd15, 32'd2, 3'b111, 5'd12, T);
    get_rsp(0, r, c, d, e);
    chk("moddt_res", 64'(r), 64'd1);
    chk("moddt_err", 64'(e), 64'd0);

    // Reset two cycles into a modulo op, then SUB 36-5
    send(32'd15, 32'd2, 3'b111, 5'd13, 1000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_alu_start", 64'(alu_start), 64'd0);
    chk("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rstmid_req_ready", 64'(req_ready), 64'd1);
    send(32'd36, 32'd5, 3'b110, 5'd14, 1);
    get_rsp(0, r, c, d, e);
    chk("sub_res", 64'(r), 64'd31);
    chk("sub_dst", 64'(d), 64'd14);
    chk("sub_err", 64'(e), 64'd0);

    // Randomized traffic; the compare process checks every cycle
    for (int n = 0; n < 150; n++) begin
      op = 3'($urandom_range(0, 7));
      b  = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      if (op == 3'b111 && $urandom_range(0, 1) == 1) b = W'($urandom_range(1, 9));
      send(W'($urandom), b, op, TW'($urandom_range(0, 31)), $urandom_range(1, T + 3));
      get_rsp($urandom_range(0, 3), r, c, d, e);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
